// File: rtl/debounce_pulse_gen.sv
// Per-channel input conditioning: two-flop synchronizer, debounce counter,
// registered rise/fall pulses and a non-retriggerable fixed-width stretch.
module debounce_pulse_gen #(
  parameter int CH      = 3,
  parameter int DEB_CYC = 16,
  parameter int CNT_W   = 16,
  parameter int PW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [CH-1:0] raw_in,
  output logic [CH-1:0] level_out,
  output logic [CH-1:0] rise_pulse,
  output logic [CH-1:0] fall_pulse,
  output logic [CH-1:0] stretch_out,
  output logic [CH-1:0] busy
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [7:0]       PW_LAST  = 8'(PW - 1);

  logic [CH-1:0]    s1_r, s2_r;
  logic [CH-1:0]    level_r, rise_r, fall_r, stretch_r;
  logic [CH-1:0]    level_s, rise_s, fall_s, stretch_s;
  logic [CNT_W-1:0] cnt_r  [CH];
  logic [CNT_W-1:0] cnt_s  [CH];
  logic [7:0]       scnt_r [CH];
  logic [7:0]       scnt_s [CH];

  // Synchronizer flops run regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= {CH{1'b0}};
      s2_r <= {CH{1'b0}};
    end else begin
      s1_r <= raw_in;
      s2_r <= s1_r;
    end
  end

  // Next-state for debounce counters, accepted level, pulses and stretch.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      level_s[i]   = level_r[i];
      rise_s[i]    = 1'b0;
      fall_s[i]    = 1'b0;
      cnt_s[i]     = {CNT_W{1'b0}};
      stretch_s[i] = stretch_r[i];
      scnt_s[i]    = scnt_r[i];

      if (!ena) begin
        cnt_s[i] = {CNT_W{1'b0}};
      end else if (s2_r[i] == level_r[i]) begin
        cnt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == DEB_LAST) begin
        level_s[i] = s2_r[i];
        rise_s[i]  = s2_r[i];
        fall_s[i]  = ~s2_r[i];
      end else begin
        cnt_s[i] = cnt_r[i] + CNT_W'(1);
      end

      // A rise seen while stretching is dropped: no retrigger, no extension.
      if (stretch_r[i]) begin
        if (scnt_r[i] == 8'd0) begin
          stretch_s[i] = 1'b0;
        end else begin
          scnt_s[i] = scnt_r[i] - 8'd1;
        end
      end else if (rise_s[i]) begin
        stretch_s[i] = 1'b1;
        scnt_s[i]    = PW_LAST;
      end else begin
        scnt_s[i] = scnt_r[i];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r   <= {CH{1'b0}};
      rise_r    <= {CH{1'b0}};
      fall_r    <= {CH{1'b0}};
      stretch_r <= {CH{1'b0}};
      for (int i = 0; i < CH; i++) begin
        cnt_r[i]  <= {CNT_W{1'b0}};
        scnt_r[i] <= 8'd0;
      end
    end else begin
      level_r   <= level_s;
      rise_r    <= rise_s;
      fall_r    <= fall_s;
      stretch_r <= stretch_s;
      for (int i = 0; i < CH; i++) begin
        cnt_r[i]  <= cnt_s[i];
        scnt_r[i] <= scnt_s[i];
      end
    end
  end

  assign level_out   = level_r;
  assign rise_pulse  = rise_r;
  assign fall_pulse  = fall_r;
  assign stretch_out = stretch_r;
  assign busy        = stretch_r;

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Directed bench: dut uses DEB_CYC=4/PW=3, dut1 uses DEB_CYC=1/PW=3.
module tb_debounce_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n, ena, ena1;
  logic [2:0] raw_in, level_out, rise_pulse, fall_pulse, stretch_out, busy;
  logic [1:0] raw1, level1, rise1, fall1, stretch1, busy1;
  int checks = 0;
  int errors = 0;

  debounce_pulse_gen #(.CH(3), .DEB_CYC(4), .CNT_W(16), .PW(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_in(raw_in),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .stretch_out(stretch_out), .busy(busy)
  );

  debounce_pulse_gen #(.CH(2), .DEB_CYC(1), .CNT_W(4), .PW(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .raw_in(raw1),
    .level_out(level1), .rise_pulse(rise1), .fall_pulse(fall1),
    .stretch_out(stretch1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; ena1 = 1'b1; raw_in = 3'b000; raw1 = 2'b00;
    #1;
    checks++;
    if ({level_out, rise_pulse, fall_pulse, stretch_out, busy} !== 15'd0) begin
      errors++;
      $display("FAIL reset_dut got %b exp 0", {level_out, rise_pulse, fall_pulse, stretch_out, busy});
    end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    checks++;
    if ({level_out, rise_pulse, fall_pulse, stretch_out, busy, level1, rise1, fall1, stretch1, busy1} !== 25'd0) begin
      errors++;
      $display("FAIL reset_release got %b exp 0",
               {level_out, rise_pulse, fall_pulse, stretch_out, busy, level1, rise1, fall1, stretch1, busy1});
    end
  endtask

  task automatic test_rise();
    logic [4:0] got, exp;
    raw_in[0] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      exp = {n >= 6, n == 6, 1'b0, (n >= 6) && (n <= 8), (n >= 6) && (n <= 8)};
      got = {level_out[0], rise_pulse[0], fall_pulse[0], stretch_out[0], busy[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rise step %0d got %b exp %b", n, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat = 5'b10101;
    logic [4:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      raw_in[1] = pat[i];
      if (i < 4) begin
        step();
        checks++;
        if ({level_out[1], rise_pulse[1], fall_pulse[1]} !== 3'b000) begin
          errors++;
          $display("FAIL bounce_toggle %0d got %b exp 000", i, {level_out[1], rise_pulse[1], fall_pulse[1]});
        end
      end
    end
    for (int n = 1; n <= 10; n++) begin
      step();
      exp = {n >= 6, n == 6, 1'b0, (n >= 6) && (n <= 8), (n >= 6) && (n <= 8)};
      got = {level_out[1], rise_pulse[1], fall_pulse[1], stretch_out[1], busy[1]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bounce_hold step %0d got %b exp %b", n, got, exp);
      end
    end
  endtask

  task automatic test_fall();
    logic [4:0] got, exp;
    raw_in[0] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      exp = {n < 6, 1'b0, n == 6, 1'b0, 1'b0};
      got = {level_out[0], rise_pulse[0], fall_pulse[0], stretch_out[0], busy[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fall step %0d got %b exp %b", n, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    raw1[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      exp = {(n == 3) || (n >= 5), (n == 3) || (n == 5), n == 4,
             (n >= 3) && (n <= 5), (n >= 3) && (n <= 5)};
      got = {level1[0], rise1[0], fall1[0], stretch1[0], busy1[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back step %0d got %b exp %b", n, got, exp);
      end
      if (n == 1) raw1[0] = 1'b0;
      if (n == 2) raw1[0] = 1'b1;
    end
  endtask

  task automatic test_enable();
    logic [3:0] got, exp;
    ena = 1'b0;
    raw_in[2] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      checks++;
      if ({level_out[2], rise_pulse, fall_pulse} !== 7'd0) begin
        errors++;
        $display("FAIL ena_low step %0d got %b exp 0", n, {level_out[2], rise_pulse, fall_pulse});
      end
    end
    ena = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      exp = {n >= 4, n == 4, 1'b0, (n >= 4) && (n <= 6)};
      got = {level_out[2], rise_pulse[2], fall_pulse[2], stretch_out[2]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ena_return step %0d got %b exp %b", n, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] got, exp;
    logic [9:0]  got1, exp1;
    raw_in[0] = 1'b1;
    raw1[1]   = 1'b1;
    for (int n = 1; n <= 3; n++) step();
    checks++;
    if ({level_out[0], rise_pulse[0], stretch1[1]} !== 3'b001) begin
      errors++;
      $display("FAIL pre_reset got %b exp 001", {level_out[0], rise_pulse[0], stretch1[1]});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({level_out, rise_pulse, fall_pulse, stretch_out, busy, level1, rise1, fall1, stretch1, busy1} !== 25'd0) begin
      errors++;
      $display("FAIL reset_async got %b exp 0",
               {level_out, rise_pulse, fall_pulse, stretch_out, busy, level1, rise1, fall1, stretch1, busy1});
    end
    step(); step();
    rst_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      exp  = {{3{n >= 6}}, {3{n == 6}}, 3'b000, {3{(n >= 6) && (n <= 8)}}, {3{(n >= 6) && (n <= 8)}}};
      got  = {level_out, rise_pulse, fall_pulse, stretch_out, busy};
      exp1 = {{2{n >= 3}}, {2{n == 3}}, 2'b00, {2{(n >= 3) && (n <= 5)}}, {2{(n >= 3) && (n <= 5)}}};
      got1 = {level1, rise1, fall1, stretch1, busy1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reacquire step %0d got %b exp %b", n, got, exp);
      end
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL reacquire1 step %0d got %b exp %b", n, got1, exp1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_bounce();
    test_fall();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_pulse_gen.md
Name: debounce_pulse_gen

Overview:
- Upstream conditioning stage for the synchronizer test top. Takes raw switch/button levels from the dedicated input pins (strobe, pulse request and similar) and delivers clean versions in the source clock domain.
- Each channel is double-flopped, then debounced. The block then emits a stable level, single-cycle rise/fall pulses, and a fixed-width stretched pulse.
- These outputs drive the strobe/pulse inputs of the pulse and toggle synchronizers, so they never see bounce or multi-cycle glitches.

Parameters:
- CH, 3, number of independent input channels.
- DEB_CYC, 16, consecutive differing synchronized samples required to accept a new level (legal range 1..65535).
- CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DEB_CYC.
- PW, 4, stretched-pulse width in clk cycles (legal range 1..255).

Ports:
- clk  in  1  single clock of the block
- rst_n  in  1  asynchronous reset, active low
- ena  in  1  channel enable; low freezes accepted levels and suppresses events
- raw_in  in  CH  asynchronous raw switch levels
- level_out  out  CH  debounced stable level
- rise_pulse  out  CH  one-cycle pulse on accepted 0->1
- fall_pulse  out  CH  one-cycle pulse on accepted 1->0
- stretch_out  out  CH  PW-cycle pulse launched by an accepted rise
- busy  out  CH  high while stretch_out of that channel is active

Behaviour:
- Reset (async assert, registers released on next clk): sync flops, level_out, rise_pulse, fall_pulse, stretch_out, busy all 0; debounce and stretch counters 0.
- Sync stage: s1 <= raw_in[i]; s2 <= s1. The sync flops always run, ignoring ena.
- Debounce, per channel, with ena=1:
  - s2 == level_out[i]: counter cleared to 0.
  - s2 != level_out[i] and counter < DEB_CYC-1: counter increments.
  - s2 != level_out[i] and counter == DEB_CYC-1: level_out[i] <= s2, counter <= 0, and the matching rise_pulse or fall_pulse is high for exactly the following cycle.
  - Any single sample equal to level_out restarts the count, so bounce shorter than DEB_CYC cycles is rejected.
- Latency: if raw_in is first sampled at edge E and then held, level_out and the pulse register update at edge E+1+DEB_CYC. With DEB_CYC=1 this is edge E+2.
- rise_pulse and fall_pulse are registered, each exactly one cycle wide, and never both high on one channel.
- Stretch:
  - An accepted rise with busy[i]=0 sets stretch_out[i]=busy[i]=1 on the same edge as rise_pulse; they stay high for exactly PW cycles.
  - A rise accepted while busy=1 is ignored; there is no retrigger or extension.
  - A fall does not cut the stretch short.
- ena=0:
  - Debounce counters are held at 0 and level_out is held.
  - rise_pulse and fall_pulse are forced 0 from the next edge.
  - An in-progress stretch runs to completion.
  - When ena returns high, a differing s2 must accumulate a full DEB_CYC samples before acceptance.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Reset mid-count or mid-stretch aborts immediately to the reset values. No pulse is emitted after release unless a full new debounce completes.

Test Plan:
- DEB_CYC=4, PW=3. raw_in[0] 0->1 at edge 10, held -> level_out[0]=1 and rise_pulse[0]=1 at edge 15 only; stretch_out[0] high for edges 15..17; busy matches.
- raw_in[1] toggles 1,0,1,0,1 every cycle, then held 1 -> no pulse during the toggling; exactly one rise_pulse, 5 cycles after the final hold begins (edge E+1+4).
- level_out[0]=1, raw_in[0] 1->0 held -> single fall_pulse[0]; stretch_out stays 0.
- Rise, fall, rise accepted within PW=3 cycles (DEB_CYC=1) -> second rise_pulse appears; stretch_out stays one 3-cycle pulse and is not extended.
- ena=0 while raw_in[2] changes and is held 10 cycles -> level_out unchanged, no pulses. ena=1 -> acceptance exactly DEB_CYC=4 edges later.
- rst_n pulsed low at debounce count 2 and mid-stretch -> all outputs 0 immediately; after release with raw held, re-acceptance takes the full DEB_CYC+2 edges.
